pwm_capture: RTL and testbench



---
 rtl/pwm_pkg.sv | 13 +
 rtl/sync_edge.sv | 31 +++
 rtl/pwm_capture.sv | 156 +++++++++++++++
 tb/tb_pwm_capture.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM capture path.
package pwm_pkg;

  localparam int PWM_INTERVAL_DEF = 1200;
  localparam int TIMEOUT_DEF      = 2400;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } cap_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus rising-edge detection
// on the synchronised level.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pwm,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Metastability chain; r_s3 keeps the previous synchronised level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_pwm;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input, flags a stuck
// input, and reports lock when consecutive periods match.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int PWM_INTERVAL = PWM_INTERVAL_DEF,
  parameter int WIDTH        = 11,
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int CNT_W        = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] width_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             stuck,
  output logic             locked
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [WIDTH-1:0] W_MAX     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] W_FULL    =
    (PWM_INTERVAL > 32'(W_MAX)) ? W_MAX : WIDTH'(PWM_INTERVAL);

  function automatic logic [WIDTH-1:0] sat_width(input logic [CNT_W-1:0] v);
    if (32'(v) > 32'(W_MAX)) begin
      return W_MAX;
    end else begin
      return WIDTH'(v);
    end
  endfunction

  logic             w_level;
  logic             w_rise;
  logic             w_meas;
  logic             w_tmo;
  cap_state_t       r_state;
  cap_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_prev_per;
  logic [WIDTH-1:0] r_width;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_stuck;
  logic             r_locked;

  sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pwm   (pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  // Next state; a rise always takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_meas      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE, MEASURE: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_meas      = (r_state == MEASURE);
        end else if (r_per_cnt == TIMEOUT_C) begin
          w_state_nxt = STUCK;
          w_tmo       = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      STUCK: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
        end else begin
          w_state_nxt = STUCK;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Period and high-time counters, both saturating at the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_cnt <= {CNT_W{1'b0}};
      r_hi_cnt  <= {CNT_W{1'b0}};
    end else if (w_rise) begin
      r_per_cnt <= CNT_W'(1'b1);
      r_hi_cnt  <= CNT_W'(1'b1);
    end else begin
      if (r_per_cnt != TIMEOUT_C) begin
        r_per_cnt <= r_per_cnt + CNT_W'(1'b1);
      end else begin
        r_per_cnt <= r_per_cnt;
      end
      if (w_level && (r_hi_cnt != TIMEOUT_C)) begin
        r_hi_cnt <= r_hi_cnt + CNT_W'(1'b1);
      end else begin
        r_hi_cnt <= r_hi_cnt;
      end
    end
  end

  // Result registers: measurement on a MEASURE rise, stuck report on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_width    <= {WIDTH{1'b0}};
      r_period   <= {CNT_W{1'b0}};
      r_prev_per <= {CNT_W{1'b0}};
      r_valid    <= 1'b0;
      r_stuck    <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_valid <= w_meas | w_tmo;
      r_stuck <= (w_state_nxt == STUCK);
      if (w_meas) begin
        r_width    <= sat_width(r_hi_cnt);
        r_period   <= r_per_cnt;
        r_locked   <= (r_per_cnt == r_prev_per);
        r_prev_per <= r_per_cnt;
      end else if (w_tmo) begin
        // A stuck-high pin reads as full scale, stuck-low as zero duty.
        r_width    <= w_level ? W_FULL : {WIDTH{1'b0}};
        r_period   <= {CNT_W{1'b0}};
        r_locked   <= 1'b0;
        r_prev_per <= {CNT_W{1'b0}};
      end else begin
        r_width    <= r_width;
        r_period   <= r_period;
        r_locked   <= r_locked;
        r_prev_per <= r_prev_per;
      end
    end
  end

  assign width_out  = r_width;
  assign period_out = r_period;
  assign valid      = r_valid;
  assign stuck      = r_stuck;
  assign locked     = r_locked;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: default instance plus a WIDTH=8 instance
// sharing the same input, checked on every valid strobe.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [10:0] width_out;
  logic [11:0] period_out;
  logic        valid, stuck, locked;
  logic [7:0]  width8;
  logic [11:0] period8;
  logic        valid8, stuck8, locked8;

  pwm_capture dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .width_out(width_out), .period_out(period_out),
    .valid(valid), .stuck(stuck), .locked(locked)
  );

  pwm_capture #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .width_out(width8), .period_out(period8),
    .valid(valid8), .stuck(stuck8), .locked(locked8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    int w11;
    int w8;
    int per;
    int lk;
    int st;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int at, input int w11, input int w8, input int per,
                      input int lk, input int st);
    exp_t e;
    e.at = at; e.w11 = w11; e.w8 = w8; e.per = per; e.lk = lk; e.st = st;
    q.push_back(e);
  endtask

  // The measurement closed by a rise driven now appears 3 edges later.
  task automatic push_meas(input int w11, input int w8, input int per, input int lk);
    push(cyc + 3, w11, w8, per, lk, 0);
  endtask

  task automatic drive_period(input int h, input int p);
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  // Monitor: every valid strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (valid || valid8)) begin
      chk("valid_pair", 32'(valid8), 32'(valid));
      chk("valid_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("valid_cycle", 32'(cyc), 32'(e.at));
        chk("width_out", 32'(width_out), 32'(e.w11));
        chk("width8_out", 32'(width8), 32'(e.w8));
        chk("period_out", 32'(period_out), 32'(e.per));
        chk("period8_out", 32'(period8), 32'(e.per));
        chk("locked", 32'(locked), 32'(e.lk));
        chk("stuck", 32'(stuck), 32'(e.st));
      end
    end
  end

  initial begin
    int r;
    int d;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {width_out, period_out, valid, stuck, locked}, 32'd0);
    chk("rst_outputs8", {width8, period8, valid8, stuck8, locked8}, 32'd0);

    // Low from reset: per_cnt reaches TIMEOUT after edge r+2400, reported at r+2401.
    rst_n = 1'b1;
    r = cyc;
    push(r + 2401, 0, 0, 0, 0, 1);
    repeat (2410) @(negedge clk);
    chk("stuck_from_low", 32'(stuck), 32'd1);

    // Rise out of STUCK is discarded; then three 1200 and three 1000 periods.
    drive_period(300, 1200);
    chk("stuck_cleared_a", 32'(stuck), 32'd0);
    push_meas(300, 255, 1200, 0);
    drive_period(300, 1200);
    push_meas(300, 255, 1200, 1);
    drive_period(300, 1200);
    push_meas(300, 255, 1200, 1);
    drive_period(300, 1000);
    push_meas(300, 255, 1000, 0);
    drive_period(300, 1000);
    push_meas(300, 255, 1000, 1);
    drive_period(300, 1000);

    // Hold high after lock: stuck reported TIMEOUT edges after the last rise.
    push_meas(300, 255, 1000, 1);
    d = cyc;
    push(d + 2403, 1200, 255, 0, 0, 1);
    pwm_in = 1'b1;
    repeat (2410) @(negedge clk);
    chk("stuck_from_high", 32'(stuck), 32'd1);
    chk("locked_after_stuck", 32'(locked), 32'd0);

    pwm_in = 1'b0;
    repeat (100) @(negedge clk);
    drive_period(400, 1100);
    chk("stuck_cleared_b", 32'(stuck), 32'd0);
    push_meas(400, 255, 1100, 0);
    drive_period(400, 1200);
    push_meas(400, 255, 1200, 0);
    drive_period(400, 1200);

    // Reset in the middle of a high phase.
    push_meas(400, 255, 1200, 1);
    pwm_in = 1'b1;
    repeat (100) @(negedge clk);
    chk("locked_before_rst", 32'(locked), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {width_out, period_out, valid, stuck, locked}, 32'd0);
    chk("midrst_outputs8", {width8, period8, valid8, stuck8, locked8}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    // Still-high pin gives the first rise at edge r+3; the next rise closes a 200-cycle period.
    repeat (50) @(negedge clk);
    pwm_in = 1'b0;
    repeat (150) @(negedge clk);
    chk("rise_spacing", 32'(cyc - r), 32'd200);
    push_meas(50, 50, 200, 0);
    drive_period(300, 1200);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
